uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg_if.sv | 30 +++
 rtl/uart_tx_cfg.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Transmit-side handshake and line bundle for uart_tx_cfg.
// master: frame producer; slave: the transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data_in;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output tx_data_in,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data_in,
    input  tx_valid,
    output tx_ready,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first,
// optional parity bit, STOP_BITS stop bits; each bit lasts CLK_DIV clocks.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit
// (even, or odd when PARITY_ODD=1) between the data and stop bits.
module uart_tx_cfg #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_cfg_if.slave bus
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = 4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // An out-of-range configuration never accepts a frame.
  localparam bit PARAMS_OK = (CLK_DIV >= 2) && (CLK_DIV <= 65535) &&
                             (DATA_W >= 5) && (DATA_W <= 9) &&
                             ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                             (PARITY_ODD <= 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                tx_ready_q, tx_ready_d;
  logic                tx_busy_q, tx_busy_d;
  logic                tx_done_q, tx_done_d;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next state; tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    bit_end   = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_valid && tx_ready_q) begin
          state_d  = START;
          shift_d  = bus.tx_data_in;
          baud_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^bus.tx_data_in) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        // Registered pulse lands in the final cycle of the last stop bit.
        if ((bit_q == STOP_LAST) && (baud_q == BAUD_PRE)) begin
          tx_done_d = 1'b1;
        end
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    tx_ready_d = (state_d == IDLE) && PARAMS_OK;
    tx_busy_d  = (state_d != IDLE);
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_busy  = tx_busy_q;
  assign bus.tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1 and 5-bit/2-stop instances, plus
// even/odd parity instances when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] tb_data;
  logic       tb_valid;
  int         sel;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_W(8)) if_a ();
  uart_tx_cfg_if #(.DATA_W(5)) if_b ();

  uart_tx_cfg #(.CLK_DIV(4), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  uart_tx_cfg #(.CLK_DIV(3), .DATA_W(5), .STOP_BITS(2), .PARITY_ODD(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  assign if_a.tx_data_in = tb_data[7:0];
  assign if_a.tx_valid   = tb_valid && (sel == 0);
  assign if_b.tx_data_in = tb_data[4:0];
  assign if_b.tx_valid   = tb_valid && (sel == 1);

`ifdef UART_TX_PARITY_EN
  uart_tx_cfg_if #(.DATA_W(8)) if_c ();
  uart_tx_cfg_if #(.DATA_W(8)) if_d ();
  uart_tx_cfg #(.CLK_DIV(2), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));
  uart_tx_cfg #(.CLK_DIV(2), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(1))
    dut_d (.clk(clk), .rst(rst), .bus(if_d));
  assign if_c.tx_data_in = tb_data[7:0];
  assign if_c.tx_valid   = tb_valid && (sel == 2);
  assign if_d.tx_data_in = tb_data[7:0];
  assign if_d.tx_valid   = tb_valid && (sel == 3);
`endif

  logic obs_tx, obs_ready, obs_busy, obs_done;

  always_comb begin
    obs_tx    = if_a.tx;
    obs_ready = if_a.tx_ready;
    obs_busy  = if_a.tx_busy;
    obs_done  = if_a.tx_done;
    case (sel)
      1: begin
        obs_tx = if_b.tx; obs_ready = if_b.tx_ready;
        obs_busy = if_b.tx_busy; obs_done = if_b.tx_done;
      end
`ifdef UART_TX_PARITY_EN
      2: begin
        obs_tx = if_c.tx; obs_ready = if_c.tx_ready;
        obs_busy = if_c.tx_busy; obs_done = if_c.tx_done;
      end
      3: begin
        obs_tx = if_d.tx; obs_ready = if_d.tx_ready;
        obs_busy = if_d.tx_busy; obs_done = if_d.tx_done;
      end
`endif
      default: ;
    endcase
  end

  function automatic int cfg_div(input int s);
    case (s)
      0: return 4;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_dw(input int s);
    return (s == 1) ? 5 : 8;
  endfunction

  function automatic int cfg_sb(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int cfg_odd(input int s);
    return (s == 3) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame on instance s and checks every cycle of the line.
  task automatic send_frame(input int s, input logic [8:0] d, input bit scramble,
                            input string name);
    int   cd, dw, sb, nb;
    logic exp_bits [0:15];
    logic par;
    logic exp_done;
    bit   got;
    sel = s;
    cd  = cfg_div(s);
    dw  = cfg_dw(s);
    sb  = cfg_sb(s);
    nb  = 1 + dw + P + sb;
    par = 1'(cfg_odd(s));
    exp_bits[0] = 1'b0;
    for (int i = 0; i < dw; i++) begin
      exp_bits[1 + i] = d[i];
      par = par ^ d[i];
    end
    if (P == 1) exp_bits[1 + dw] = par;
    for (int i = 0; i < sb; i++) exp_bits[1 + dw + P + i] = 1'b1;

    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (obs_ready) got = 1'b1;
      else tick();
    end
    n_checks++;
    if (got !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: tx_ready=%b required 1", name, obs_ready);
    end

    tb_data  = d;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_after_hs: tx_ready=%b required 0", name, obs_ready);
    end

    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cd; c++) begin
        if (scramble) tb_data = 9'($urandom);
        exp_done = ((b == nb - 1) && (c == cd - 1)) ? 1'b1 : 1'b0;
        n_checks++;
        if (obs_tx !== exp_bits[b]) begin
          n_fail++;
          $display("FAIL %s tx bit %0d cycle %0d: tx=%b required %b",
                   name, b, c, obs_tx, exp_bits[b]);
        end
        n_checks++;
        if (obs_done !== exp_done) begin
          n_fail++;
          $display("FAIL %s tx_done bit %0d cycle %0d: tx_done=%b required %b",
                   name, b, c, obs_done, exp_done);
        end
        n_checks++;
        if (obs_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s tx_busy bit %0d cycle %0d: tx_busy=%b required 1",
                   name, b, c, obs_busy);
        end
        tick();
      end
    end

    n_checks++;
    if ({obs_ready, obs_busy, obs_done, obs_tx} !== 4'b1001) begin
      n_fail++;
      $display("FAIL %s after_frame: ready/busy/done/tx=%b%b%b%b required 1001",
               name, obs_ready, obs_busy, obs_done, obs_tx);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tb_valid = 1'b0;
    tb_data  = '0;
    sel      = 0;
    repeat (3) tick();
    n_checks++;
    if ({obs_tx, obs_ready, obs_busy, obs_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_a: tx/ready/busy/done=%b%b%b%b required 1000",
               obs_tx, obs_ready, obs_busy, obs_done);
    end
    sel = 1;
    n_checks++;
    if ({obs_tx, obs_ready, obs_busy, obs_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_b: tx/ready/busy/done=%b%b%b%b required 1000",
               obs_tx, obs_ready, obs_busy, obs_done);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_b: tx_ready=%b required 1", obs_ready);
    end
    sel = 0;
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_a: tx_ready=%b required 1", obs_ready);
    end
  endtask

  task automatic test_8n1();
    send_frame(0, 9'h055, 1'b0, "frame_55");
    send_frame(0, 9'h0C3, 1'b0, "frame_c3");
  endtask

  task automatic test_dw5_stop2();
    send_frame(1, 9'h01F, 1'b0, "dw5_1f");
    send_frame(1, 9'h00A, 1'b0, "dw5_0a");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    send_frame(2, 9'h007, 1'b0, "par_even_07");
    send_frame(3, 9'h007, 1'b0, "par_odd_07");
  endtask
`endif

  // Back-to-back frames with tx_valid held; decoded by a bench receiver.
  task automatic test_back_to_back();
    logic samp [0:199];
    int   hs_cyc [0:1];
    int   starts [0:3];
    logic [7:0] rx [0:3];
    int   hs, ns, i, ncyc;
    bit   pend;
    localparam int FL = 4 * (10 + P);
    sel      = 0;
    hs       = 0;
    hs_cyc[0] = -1;
    hs_cyc[1] = -1;
    ncyc     = 2 * FL + 20;
    tb_data  = 9'h0A5;
    tb_valid = 1'b1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      samp[cyc] = obs_tx;
      pend = obs_ready && tb_valid;
      tick();
      if (pend) begin
        if (hs < 2) hs_cyc[hs] = cyc;
        hs++;
        if (hs == 1) tb_data = 9'h03C;
        else tb_valid = 1'b0;
      end
    end
    tb_valid = 1'b0;

    ns = 0;
    i  = 0;
    while (i < ncyc) begin
      if (samp[i] == 1'b0 && (i == 0 || samp[i - 1] == 1'b1) && ns < 4) begin
        starts[ns] = i;
        rx[ns] = '0;
        for (int k = 0; k < 8; k++) begin
          if (i + 4 * (k + 1) + 2 < ncyc) rx[ns][k] = samp[i + 4 * (k + 1) + 2];
        end
        ns++;
        i = i + FL;
      end else begin
        i++;
      end
    end

    n_checks++;
    if (hs !== 2) begin
      n_fail++;
      $display("FAIL b2b_handshakes: count=%0d required 2", hs);
    end
    n_checks++;
    if (ns !== 2) begin
      n_fail++;
      $display("FAIL b2b_start_count: count=%0d required 2", ns);
    end
    if (ns >= 2) begin
      n_checks++;
      if (starts[1] - starts[0] !== FL + 1) begin
        n_fail++;
        $display("FAIL b2b_spacing: spacing=%0d required %0d",
                 starts[1] - starts[0], FL + 1);
      end
      n_checks++;
      if (starts[0] !== hs_cyc[0] + 1) begin
        n_fail++;
        $display("FAIL b2b_latency: start at %0d required %0d",
                 starts[0], hs_cyc[0] + 1);
      end
      n_checks++;
      if (rx[0] !== 8'hA5) begin
        n_fail++;
        $display("FAIL b2b_byte0: got %h required a5", rx[0]);
      end
      n_checks++;
      if (rx[1] !== 8'h3C) begin
        n_fail++;
        $display("FAIL b2b_byte1: got %h required 3c", rx[1]);
      end
    end
  endtask

  // One-cycle reset during data bit 3 aborts the frame silently.
  task automatic test_mid_reset();
    bit seen_done, seen_low;
    sel = 0;
    for (int w = 0; w < 20 && !obs_ready; w++) tick();
    tb_data  = 9'h000;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    repeat (17) tick();
    n_checks++;
    if ({obs_tx, obs_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL midrst_before: tx/busy=%b%b required 01", obs_tx, obs_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({obs_tx, obs_busy, obs_done, obs_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrst_after: tx/busy/done/ready=%b%b%b%b required 1000",
               obs_tx, obs_busy, obs_done, obs_ready);
    end
    tick();
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_release: tx_ready=%b required 1", obs_ready);
    end
    seen_done = 1'b0;
    seen_low  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (obs_done) seen_done = 1'b1;
      if (!obs_tx)  seen_low  = 1'b1;
      tick();
    end
    n_checks++;
    if ({seen_done, seen_low} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_quiet: saw tx_done=%b saw tx low=%b required 0 0",
               seen_done, seen_low);
    end
    send_frame(0, 9'h081, 1'b0, "midrst_81");
  endtask

  task automatic test_data_hold();
    send_frame(0, 9'h096, 1'b1, "hold_96");
    send_frame(1, 9'h013, 1'b1, "hold_dw5_13");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    tb_valid = 1'b0;
    tb_data  = '0;
    sel      = 0;
    test_reset();
    test_8n1();
    test_dw5_stop2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_mid_reset();
    test_data_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
